// File: rtl/systolic_2x2.sv
// Output-stationary 2x2 systolic matrix multiplier with start/busy/done handshake.
// Each PE accumulates a_ik*b_kj from skewed edge feeds; results saturate to OW bits.
module systolic_2x2 #(
  parameter int unsigned DW = 4,
  parameter int unsigned OW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [DW-1:0] a11,
  input  logic [DW-1:0] a12,
  input  logic [DW-1:0] a21,
  input  logic [DW-1:0] a22,
  input  logic [DW-1:0] b11,
  input  logic [DW-1:0] b12,
  input  logic [DW-1:0] b21,
  input  logic [DW-1:0] b22,
  output logic          busy,
  output logic          done,
  output logic [OW-1:0] sa_2x2_11,
  output logic [OW-1:0] sa_2x2_12,
  output logic [OW-1:0] sa_2x2_21,
  output logic [OW-1:0] sa_2x2_22
);

  localparam int unsigned PW      = 2 * DW;
  localparam int unsigned AW      = PW + 1;
  localparam int unsigned SAT_MAX = (1 << OW) - 1;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_UPDATE} state_e;

  // Element index in packed arrays: 0=11, 1=12, 2=21, 3=22
  state_e                   state_q, state_d;
  logic [1:0]               t_q, t_d;
  logic [3:0][DW-1:0]       opa_q, opa_d, opb_q, opb_d;
  logic [3:0][AW-1:0]       acc_q, acc_d;
  logic [DW-1:0]            ah11_q, ah11_d, ah21_q, ah21_d;
  logic [DW-1:0]            bv11_q, bv11_d, bv12_q, bv12_d;
  logic [3:0][OW-1:0]       sa_q, sa_d;
  logic                     busy_q, busy_d, done_q, done_d;

  logic [DW-1:0]            ea1, ea2, eb1, eb2;
  logic [3:0][DW-1:0]       pe_a, pe_b;

  function automatic logic [OW-1:0] sat(input logic [AW-1:0] v);
    if (v > AW'(SAT_MAX)) return '1;
    return OW'(v);
  endfunction

  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    acc_d   = acc_q;
    ah11_d  = ah11_q;
    ah21_d  = ah21_q;
    bv11_d  = bv11_q;
    bv12_d  = bv12_q;
    sa_d    = sa_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    ea1     = '0;
    ea2     = '0;
    eb1     = '0;
    eb2     = '0;

    // Skewed edge feed: row i / column j delayed by i-1 / j-1 steps
    case (t_q)
      2'd0: begin
        ea1 = opa_q[0];
        eb1 = opb_q[0];
      end
      2'd1: begin
        ea1 = opa_q[1];
        ea2 = opa_q[2];
        eb1 = opb_q[2];
        eb2 = opb_q[1];
      end
      2'd2: begin
        ea2 = opa_q[3];
        eb2 = opb_q[3];
      end
      default: ;
    endcase

    pe_a = {ah21_q, ea2, ah11_q, ea1};
    pe_b = {bv12_q, bv11_q, eb2, eb1};

    case (state_q)
      S_IDLE: begin
        opa_d  = {a22, a21, a12, a11};
        opb_d  = {b22, b21, b12, b11};
        acc_d  = '0;
        ah11_d = '0;
        ah21_d = '0;
        bv11_d = '0;
        bv12_d = '0;
        t_d    = '0;
        if (start) begin
          state_d = S_LOAD;
          busy_d  = 1'b1;
        end
      end
      S_LOAD: begin
        state_d = S_RUN;
        t_d     = '0;
      end
      S_RUN: begin
        for (int i = 0; i < 4; i++) begin
          acc_d[i] = acc_q[i] + AW'(PW'(pe_a[i]) * PW'(pe_b[i]));
        end
        ah11_d = pe_a[0];
        ah21_d = pe_a[2];
        bv11_d = pe_b[0];
        bv12_d = pe_b[1];
        t_d    = 2'(t_q + 2'd1);
        if (t_q == 2'd3) state_d = S_UPDATE;
      end
      S_UPDATE: begin
        for (int i = 0; i < 4; i++) begin
          sa_d[i] = sat(acc_q[i]);
        end
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      t_q     <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      acc_q   <= '0;
      ah11_q  <= '0;
      ah21_q  <= '0;
      bv11_q  <= '0;
      bv12_q  <= '0;
      sa_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      t_q     <= t_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      acc_q   <= acc_d;
      ah11_q  <= ah11_d;
      ah21_q  <= ah21_d;
      bv11_q  <= bv11_d;
      bv12_q  <= bv12_d;
      sa_q    <= sa_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign sa_2x2_11 = sa_q[0];
  assign sa_2x2_12 = sa_q[1];
  assign sa_2x2_21 = sa_q[2];
  assign sa_2x2_22 = sa_q[3];

endmodule

// File: tb/tb_systolic_2x2.sv
// Self-checking bench for systolic_2x2: directed and random multiplies against a
// plain matrix-product model, plus handshake, streaming and mid-run reset checks.
module tb_systolic_2x2;

  logic       clk = 1'b0;
  logic       rst, start;
  logic [3:0] a11, a12, a21, a22, b11, b12, b21, b22;
  logic       busy, done;
  logic [7:0] s11, s12, s21, s22;

  int n_checks = 0;
  int n_fail   = 0;
  int ma[2][2];
  int mb[2][2];
  int exp_c[2][2];

  systolic_2x2 dut (
    .clk(clk), .rst(rst), .start(start),
    .a11(a11), .a12(a12), .a21(a21), .a22(a22),
    .b11(b11), .b12(b12), .b21(b21), .b22(b22),
    .busy(busy), .done(done),
    .sa_2x2_11(s11), .sa_2x2_12(s12), .sa_2x2_21(s21), .sa_2x2_22(s22)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: C = A x B with ordinary arithmetic, clamped to 255
  task automatic model_update();
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 2; j++) begin
        int s = 0;
        for (int k = 0; k < 2; k++) s += ma[i][k] * mb[k][j];
        exp_c[i][j] = (s > 255) ? 255 : s;
      end
  endtask

  task automatic drive_ops();
    a11 = 4'(ma[0][0]); a12 = 4'(ma[0][1]); a21 = 4'(ma[1][0]); a22 = 4'(ma[1][1]);
    b11 = 4'(mb[0][0]); b12 = 4'(mb[0][1]); b21 = 4'(mb[1][0]); b22 = 4'(mb[1][1]);
  endtask

  task automatic set_mats(input int a0, a1, a2, a3, b0, b1, b2, b3);
    ma[0][0] = a0; ma[0][1] = a1; ma[1][0] = a2; ma[1][1] = a3;
    mb[0][0] = b0; mb[0][1] = b1; mb[1][0] = b2; mb[1][1] = b3;
  endtask

  task automatic rand_mats();
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 2; j++) begin
        ma[i][j] = int'($urandom_range(0, 15));
        mb[i][j] = int'($urandom_range(0, 15));
      end
  endtask

  task automatic check_outs(input string tag);
    check({tag, "_11"}, int'(s11), exp_c[0][0]);
    check({tag, "_12"}, int'(s12), exp_c[0][1]);
    check({tag, "_21"}, int'(s21), exp_c[1][0]);
    check({tag, "_22"}, int'(s22), exp_c[1][1]);
  endtask

  // One multiply; disturb=1 re-pulses start and scrambles operands at RUN t=1
  task automatic run_mult(input bit disturb);
    int cyc, busy_cnt, extra;
    @(negedge clk);
    drive_ops();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    busy_cnt = 0;
    while (!done && cyc < 20) begin
      if (busy) busy_cnt++;
      check_outs("held");
      if (disturb && cyc == 3) begin
        start = 1'b1;
        {a11, a12, a21, a22} = 16'($urandom);
        {b11, b12, b21, b22} = 16'($urandom);
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    check("latency", cyc - 1, 6);
    check("busy_cycles", busy_cnt, 6);
    check("busy_with_done", int'(busy), 0);
    model_update();
    check_outs("result");
    @(negedge clk);
    check("done_width", int'(done), 0);
    check_outs("after_done");
    if (disturb) begin
      extra = 0;
      repeat (8) begin
        @(negedge clk);
        if (done || busy) extra++;
      end
      check("queued_start", extra, 0);
    end
  endtask

  initial begin
    int last, ndone;
    rst = 1'b0;
    start = 1'b0;
    set_mats(0, 0, 0, 0, 0, 0, 0, 0);
    drive_ops();
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 2; j++) exp_c[i][j] = 0;
    repeat (2) @(negedge clk);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check_outs("rst_out");
    rst = 1'b1;

    set_mats(1, 2, 3, 4, 5, 6, 7, 8);
    run_mult(1'b0);
    check("plan1_11", exp_c[0][0], 19);
    set_mats(15, 15, 15, 15, 15, 15, 15, 15);
    run_mult(1'b0);
    set_mats(15, 15, 0, 1, 8, 0, 1, 1);
    run_mult(1'b0);

    for (int n = 0; n < 15; n++) begin
      rand_mats();
      run_mult(1'b0);
    end

    rand_mats();
    run_mult(1'b1);

    // Streaming with start held high
    set_mats(1, 0, 0, 1, 9, 8, 7, 6);
    @(negedge clk);
    drive_ops();
    start = 1'b1;
    last = -1;
    ndone = 0;
    model_update();
    for (int cyc = 0; cyc <= 30; cyc++) begin
      @(negedge clk);
      check("stream_excl", int'(busy & done), 0);
      if (done) begin
        if (last >= 0) check("stream_period", cyc - last, 7);
        last = cyc;
        ndone++;
        check_outs("stream");
      end
    end
    start = 1'b0;
    check("stream_dones", ndone, 4);
    repeat (10) @(negedge clk);
    check("stream_idle", int'(busy), 0);
    check_outs("stream_end");

    // Asynchronous reset at RUN t=2
    rand_mats();
    @(negedge clk);
    drive_ops();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 2; j++) exp_c[i][j] = 0;
    check("arst_busy", int'(busy), 0);
    check("arst_done", int'(done), 0);
    check_outs("arst_out");
    @(negedge clk);
    rst = 1'b1;
    ndone = 0;
    repeat (8) begin
      @(negedge clk);
      if (done || busy) ndone++;
    end
    check("abandoned_done", ndone, 0);
    check_outs("abandoned_out");
    rand_mats();
    run_mult(1'b0);
    set_mats(15, 1, 0, 0, 0, 0, 0, 15);
    run_mult(1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
